// File: rtl/key_pkg.sv
// Shared constants and types for the push-button front end.
package key_pkg;

  localparam int NUM_KEYS  = 5;

  // Button lane indices into KEY_LVL / KEY_PRESS / KEY_REL
  localparam int KEY_L     = 0;
  localparam int KEY_R     = 1;
  localparam int KEY_START = 2;
  localparam int KEY_STOP  = 3;
  localparam int KEY_FIRE  = 4;

  // Parameter defaults (1 kHz sample tick at 50 MHz)
  localparam int DEF_SAMPLE_DIV   = 50000;
  localparam int DEF_DEBOUNCE_N   = 20;
  localparam int DEF_REPEAT_DELAY = 400;
  localparam int DEF_REPEAT_RATE  = 200;

  // Auto-repeat state per direction key
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_debounce.sv
// One button lane: 2-flop synchronizer, tick-driven debounce counter,
// stable level and one-cycle edge pulses. The *_nxt outputs expose the
// values about to be registered so the repeat logic can act on the same edge.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_N = DEF_DEBOUNCE_N
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick,
  input  logic raw,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic lvl_nxt,
  output logic rise_nxt,
  output logic fall_nxt
);

  localparam int CW = $clog2(DEBOUNCE_N + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          flip;

  // Flip on the tick that would bring the disagreement count to DEBOUNCE_N
  assign flip     = tick && (sync[1] != lvl) && (cnt == CW'(DEBOUNCE_N - 1));
  assign lvl_nxt  = lvl ^ flip;
  assign rise_nxt = flip & ~lvl;
  assign fall_nxt = flip &  lvl;

  // Bring the raw asynchronous level into the CLK domain
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt <= '0;
    else if (tick) begin
      if (sync[1] == lvl || flip) cnt <= '0;
      else                        cnt <= cnt + CW'(1);
    end
  end

  // Stable level and edge pulses, all updated on the flipping edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      lvl   <= lvl_nxt;
      press <= rise_nxt;
      rel   <= fall_nxt;
    end
  end

endmodule

// File: rtl/key_frontend.sv
// Push-button front end: shared sample prescaler, five debounced lanes,
// L/R auto-repeat FSMs with mutual lockout, and the FIRE toggle.
module key_frontend
  import key_pkg::*;
#(
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int DEBOUNCE_N   = DEF_DEBOUNCE_N,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                L,
  input  logic                R,
  input  logic                START,
  input  logic                STOP,
  input  logic                FIRE,
  output logic [NUM_KEYS-1:0] KEY_LVL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_REL,
  output logic                MOVE_L,
  output logic                MOVE_R,
  output logic                FIRE_TOG
);

  localparam int PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] lvl_nxt;
  logic [NUM_KEYS-1:0] rise_nxt;
  logic [NUM_KEYS-1:0] fall_nxt;
  logic                both_nxt;
  logic [1:0]          move;
  logic                fire_tog;
  logic                unused_nxt;

  assign raw[KEY_L]     = L;
  assign raw[KEY_R]     = R;
  assign raw[KEY_START] = START;
  assign raw[KEY_STOP]  = STOP;
  assign raw[KEY_FIRE]  = FIRE;

  assign tick = (pre_cnt == PW'(SAMPLE_DIV - 1));

  // Free-running sample prescaler, one tick per SAMPLE_DIV clocks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .tick     (tick),
      .raw      (raw[k]),
      .lvl      (KEY_LVL[k]),
      .press    (KEY_PRESS[k]),
      .rel      (KEY_REL[k]),
      .lvl_nxt  (lvl_nxt[k]),
      .rise_nxt (rise_nxt[k]),
      .fall_nxt (fall_nxt[k])
    );
  end

  // Lockout uses the upcoming levels so the edge that makes both keys high
  // already suppresses any move pulse
  assign both_nxt   = lvl_nxt[KEY_L] & lvl_nxt[KEY_R];
  assign unused_nxt = ^{lvl_nxt[NUM_KEYS-1:2], rise_nxt[NUM_KEYS-1:2], fall_nxt[NUM_KEYS-1:2]};

  for (genvar i = 0; i < 2; i++) begin : g_rpt
    rpt_state_e    st;
    logic [RW-1:0] rc;
    logic [RW-1:0] rc_inc;
    logic          mv;

    // Saturating tick counter
    assign rc_inc  = (rc == {RW{1'b1}}) ? rc : rc + RW'(1);
    assign move[i] = mv;

    // Auto-repeat FSM: move on press, after REPEAT_DELAY ticks, then every REPEAT_RATE ticks
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        st <= ST_IDLE;
        rc <= '0;
        mv <= 1'b0;
      end else begin
        mv <= 1'b0;
        if (both_nxt || fall_nxt[i]) begin
          st <= ST_IDLE;
          rc <= '0;
        end else begin
          case (st)
            ST_IDLE: if (rise_nxt[i]) begin
              st <= ST_DELAY;
              rc <= '0;
              mv <= 1'b1;
            end
            ST_DELAY: if (tick) begin
              if (rc_inc >= RW'(REPEAT_DELAY)) begin
                st <= ST_RPT;
                rc <= '0;
                mv <= 1'b1;
              end else rc <= rc_inc;
            end
            ST_RPT: if (tick) begin
              if (rc_inc >= RW'(REPEAT_RATE)) begin
                rc <= '0;
                mv <= 1'b1;
              end else rc <= rc_inc;
            end
            default: begin
              st <= ST_IDLE;
              rc <= '0;
            end
          endcase
        end
      end
    end
  end

  assign MOVE_L = move[KEY_L];
  assign MOVE_R = move[KEY_R];

  // FIRE toggles once per debounced press
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                   fire_tog <= 1'b0;
    else if (KEY_PRESS[KEY_FIRE]) fire_tog <= ~fire_tog;
  end

  assign FIRE_TOG = fire_tog;

endmodule

// File: tb/tb_key_frontend.sv
// Bench for key_frontend with small timing parameters. A negedge monitor
// pops expected pulse events from a queue; tasks push expectations as they
// drive buttons and check levels, latencies and repeat spacing inline.
module tb_key_frontend;
  import key_pkg::*;

  localparam int SD = 4, DN = 3, RD = 10, RR = 4;

  logic       CLK = 0, RST_N = 0;
  logic       L = 0, R = 0, START = 0, STOP = 0, FIRE = 0;
  logic [4:0] KEY_LVL, KEY_PRESS, KEY_REL;
  logic       MOVE_L, MOVE_R, FIRE_TOG;

  typedef struct packed {
    logic [4:0] p;
    logic [4:0] r;
    logic       ml;
    logic       mr;
  } ev_t;

  ev_t exp_q[$];
  int  mvl_t[$];
  int  cyc = 0, checks = 0, errors = 0;
  bit  mon_en = 0;
  ev_t got, want;

  key_frontend #(.SAMPLE_DIV(SD), .DEBOUNCE_N(DN), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .CLK(CLK), .RST_N(RST_N), .L(L), .R(R), .START(START), .STOP(STOP), .FIRE(FIRE),
    .KEY_LVL(KEY_LVL), .KEY_PRESS(KEY_PRESS), .KEY_REL(KEY_REL),
    .MOVE_L(MOVE_L), .MOVE_R(MOVE_R), .FIRE_TOG(FIRE_TOG)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic ev_t mk(input logic [4:0] p, input logic [4:0] r, input logic ml, input logic mr);
    mk = {p, r, ml, mr};
  endfunction

  // Scoreboard: every pulse cycle must match the head of the expectation queue
  always @(negedge CLK) begin
    if (RST_N && mon_en && (KEY_PRESS != 0 || KEY_REL != 0 || MOVE_L || MOVE_R)) begin
      got = {KEY_PRESS, KEY_REL, MOVE_L, MOVE_R};
      if (MOVE_L) mvl_t.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected cyc=%0d got=%h required=none", cyc, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event_order cyc=%0d got=%h required=%h", cyc, got, want);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Bounded wait for a press pulse; t = -1 when it never comes
  task automatic wait_press(input int b, output int t);
    t = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (KEY_PRESS[b]) begin t = cyc; break; end
    end
  endtask

  task automatic test_reset;
    wait_neg(3);
    checks++;
    if ({KEY_LVL, KEY_PRESS, KEY_REL, MOVE_L, MOVE_R, FIRE_TOG} !== 18'b0) begin
      errors++; $display("FAIL reset_outputs got=%b required=0", {KEY_LVL, KEY_PRESS, KEY_REL, MOVE_L, MOVE_R, FIRE_TOG});
    end
    RST_N = 1; mon_en = 1;
    wait_neg(30);
    checks++;
    if (KEY_LVL !== 5'b0 || FIRE_TOG !== 1'b0) begin
      errors++; $display("FAIL reset_idle got=%b/%b required=00000/0", KEY_LVL, FIRE_TOG);
    end
  endtask

  task automatic test_fire;
    int t0, tp;
    exp_q.push_back(mk(5'b10000, 5'b0, 1'b0, 1'b0));
    t0 = cyc; FIRE = 1;
    wait_press(KEY_FIRE, tp);
    checks++;
    if (tp < 0 || tp - t0 < 11 || tp - t0 > 14) begin
      errors++; $display("FAIL fire_latency got=%0d required=11..14", tp < 0 ? -1 : tp - t0);
    end
    checks++;
    if (FIRE_TOG !== 1'b0) begin errors++; $display("FAIL fire_tog_early got=%b required=0", FIRE_TOG); end
    @(negedge CLK);
    checks++;
    if (FIRE_TOG !== 1'b1) begin errors++; $display("FAIL fire_tog_first got=%b required=1", FIRE_TOG); end
    wait_neg(25);
    checks++;
    if (KEY_LVL !== 5'b10000) begin errors++; $display("FAIL fire_level got=%b required=10000", KEY_LVL); end
    exp_q.push_back(mk(5'b0, 5'b10000, 1'b0, 1'b0));
    FIRE = 0; wait_neg(40);
    checks++;
    if (KEY_LVL !== 5'b0 || FIRE_TOG !== 1'b1) begin
      errors++; $display("FAIL fire_release got=%b/%b required=00000/1", KEY_LVL, FIRE_TOG);
    end
    exp_q.push_back(mk(5'b10000, 5'b0, 1'b0, 1'b0));
    FIRE = 1; wait_neg(40);
    checks++;
    if (FIRE_TOG !== 1'b0) begin errors++; $display("FAIL fire_tog_second got=%b required=0", FIRE_TOG); end
    exp_q.push_back(mk(5'b0, 5'b10000, 1'b0, 1'b0));
    FIRE = 0; wait_neg(40);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fire_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    for (int n = 0; n < 5; n++) begin
      START = 1; wait_neg(8);
      START = 0; wait_neg(8);
      checks++;
      if (KEY_LVL !== 5'b0) begin errors++; $display("FAIL glitch_level n=%0d got=%b required=00000", n, KEY_LVL); end
    end
  endtask

  task automatic test_repeat;
    int tp;
    mvl_t.delete();
    exp_q.push_back(mk(5'b00001, 5'b0, 1'b1, 1'b0));
    L = 1;
    wait_press(KEY_L, tp);
    checks++;
    if (tp < 0) begin errors++; $display("FAIL repeat_press got=none required=pulse"); end
    else begin
      for (int k = 0; k < 10; k++) exp_q.push_back(mk(5'b0, 5'b0, 1'b1, 1'b0));
      while (cyc < tp + 184) @(negedge CLK);
    end
    exp_q.push_back(mk(5'b0, 5'b00001, 1'b0, 1'b0));
    L = 0; wait_neg(40);
    checks++;
    if (mvl_t.size() != 11) begin errors++; $display("FAIL repeat_count got=%0d required=11", mvl_t.size()); end
    else begin
      checks++;
      if (mvl_t[1] - mvl_t[0] != 40) begin errors++; $display("FAIL repeat_delay got=%0d required=40", mvl_t[1] - mvl_t[0]); end
      for (int k = 2; k < 11; k++) begin
        checks++;
        if (mvl_t[k] - mvl_t[k-1] != 16) begin
          errors++; $display("FAIL repeat_rate k=%0d got=%0d required=16", k, mvl_t[k] - mvl_t[k-1]);
        end
      end
    end
    checks++;
    if (KEY_LVL !== 5'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL repeat_end got=%b/%0d required=00000/0", KEY_LVL, exp_q.size());
    end
  endtask

  task automatic test_both;
    int tp, tr;
    exp_q.push_back(mk(5'b00001, 5'b0, 1'b1, 1'b0));
    L = 1;
    wait_press(KEY_L, tp);
    exp_q.push_back(mk(5'b0, 5'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(5'b00010, 5'b0, 1'b0, 1'b0));
    while (cyc < tp + 44) @(negedge CLK);
    R = 1;
    wait_press(KEY_R, tr);
    checks++;
    if (tp < 0 || tr != tp + 56) begin errors++; $display("FAIL both_r_press got=%0d required=%0d", tr, tp + 56); end
    wait_neg(60);
    checks++;
    if (KEY_LVL !== 5'b00011) begin errors++; $display("FAIL both_level got=%b required=00011", KEY_LVL); end
    exp_q.push_back(mk(5'b0, 5'b00010, 1'b0, 1'b0));
    R = 0; wait_neg(60);
    checks++;
    if (KEY_LVL !== 5'b00001) begin errors++; $display("FAIL both_r_release got=%b required=00001", KEY_LVL); end
    exp_q.push_back(mk(5'b0, 5'b00001, 1'b0, 1'b0));
    L = 0; wait_neg(30);
    exp_q.push_back(mk(5'b00001, 5'b0, 1'b1, 1'b0));
    L = 1;
    wait_press(KEY_L, tp);
    checks++;
    if (tp < 0) begin errors++; $display("FAIL both_fresh_press got=none required=pulse"); end
    wait_neg(10);
    exp_q.push_back(mk(5'b0, 5'b00001, 1'b0, 1'b0));
    L = 0; wait_neg(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL both_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int tp, tr, t2;
    exp_q.push_back(mk(5'b00001, 5'b0, 1'b1, 1'b0));
    L = 1;
    wait_press(KEY_L, tp);
    exp_q.push_back(mk(5'b0, 5'b0, 1'b1, 1'b0));
    while (cyc < tp + 44) @(negedge CLK);
    RST_N = 0;
    #1;
    checks++;
    if ({KEY_LVL, KEY_PRESS, KEY_REL, MOVE_L, MOVE_R, FIRE_TOG} !== 18'b0) begin
      errors++; $display("FAIL rstmid_outputs got=%b required=0", {KEY_LVL, KEY_PRESS, KEY_REL, MOVE_L, MOVE_R, FIRE_TOG});
    end
    wait_neg(3);
    checks++;
    if (KEY_LVL !== 5'b0 || MOVE_L !== 1'b0) begin errors++; $display("FAIL rstmid_hold got=%b/%b required=00000/0", KEY_LVL, MOVE_L); end
    exp_q.push_back(mk(5'b00001, 5'b0, 1'b1, 1'b0));
    RST_N = 1; tr = cyc;
    wait_press(KEY_L, t2);
    checks++;
    if (t2 != tr + 12) begin errors++; $display("FAIL rstmid_repress got=%0d required=%0d", t2, tr + 12); end
    exp_q.push_back(mk(5'b0, 5'b00001, 1'b0, 1'b0));
    L = 0; wait_neg(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_simul;
    int tp;
    exp_q.push_back(mk(5'b01010, 5'b0, 1'b0, 1'b1));
    STOP = 1; R = 1;
    wait_press(KEY_STOP, tp);
    checks++;
    if (tp < 0 || KEY_PRESS !== 5'b01010) begin errors++; $display("FAIL simul_press got=%b required=01010", KEY_PRESS); end
    wait_neg(10);
    exp_q.push_back(mk(5'b0, 5'b01010, 1'b0, 1'b0));
    STOP = 0; R = 0; wait_neg(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL simul_pending got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fire();
    test_glitch();
    test_repeat();
    test_both();
    test_reset_mid();
    test_simul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_frontend.md
KEY_FRONTEND -- requirements
Module: key_frontend

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 50000, giving CLK cycles per debounce sample tick (1 kHz at 50 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_N, default 20, giving the consecutive disagreeing samples needed to change a stable level.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 400, giving the ticks from L/R press to the first auto-repeat.
REQ-004 The block SHALL have parameter REPEAT_RATE, default 200, giving the ticks between subsequent auto-repeats.
REQ-005 Port CLK, input, 1 bit: sole clock, all state on its rising edge; one clock only.
REQ-006 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Ports L, R, START, STOP, FIRE, inputs, 1 bit each: raw asynchronous push-button levels, active-high.
REQ-008 Port KEY_LVL, output, 5 bits: debounced levels; bit 0 L, 1 R, 2 START, 3 STOP, 4 FIRE.
REQ-009 Port KEY_PRESS, output, 5 bits: one-CLK pulse on each debounced rising edge, same bit order.
REQ-010 Port KEY_REL, output, 5 bits: one-CLK pulse on each debounced falling edge, same bit order.
REQ-011 Ports MOVE_L and MOVE_R, outputs, 1 bit each: one-CLK move pulses (press plus auto-repeat).
REQ-012 Port FIRE_TOG, output, 1 bit: level that toggles on each debounced FIRE press.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 A prescaler SHALL count 0..SAMPLE_DIV-1 and wrap to 0, asserting an internal tick for one CLK when the count equals SAMPLE_DIV-1.
REQ-015 On each tick, per button: if the synchronized sample differs from KEY_LVL, the counter increments; otherwise it clears to 0.
REQ-016 When the counter reaches DEBOUNCE_N on a tick, KEY_LVL SHALL invert and the counter SHALL clear, both in that same CLK edge.
REQ-017 KEY_PRESS and KEY_REL SHALL assert in the CLK cycle immediately following the KEY_LVL change and last exactly one cycle.
REQ-018 Glitches shorter than DEBOUNCE_N ticks SHALL produce no change on any output.
REQ-019 Per L and R, the repeat FSM SHALL have states IDLE, DELAY and RPT.
REQ-020 FSM IDLE->DELAY on KEY_PRESS, with MOVE pulse in that same cycle and the repeat counter loaded with 0.
REQ-021 FSM DELAY->RPT after REPEAT_DELAY ticks, emitting a MOVE pulse.
REQ-022 FSM in RPT emits a MOVE pulse every REPEAT_RATE ticks.
REQ-023 FSM returns any state->IDLE on KEY_REL, with no pulse.
REQ-024 While KEY_LVL[0] and KEY_LVL[1] are both 1, MOVE_L and MOVE_R SHALL be held 0 and both FSMs SHALL be forced to IDLE; KEY_PRESS and KEY_REL are unaffected.
REQ-025 The repeat counters SHALL saturate, never wrap, and be wide enough for REPEAT_DELAY.
REQ-026 FIRE_TOG SHALL invert in the cycle KEY_PRESS[4] is 1; releases have no effect.

Reset
REQ-027 While RST_N=0, every output SHALL be 0, with synchronizers, prescaler and counters at 0 and FSMs IDLE.
REQ-028 A button held through reset release SHALL generate KEY_PRESS DEBOUNCE_N ticks later; reset mid-repeat SHALL abort repeats with no further MOVE pulse.

Structure
REQ-029 Package key_pkg SHALL hold the button index constants (KEY_L=0 .. KEY_FIRE=4), the repeat FSM state enum, and the parameter defaults.
REQ-030 One sub-module, key_debounce (synchronizer, counter, level, edge pulses), SHALL be instantiated five times; the prescaler and repeat FSMs live in key_frontend.

Verification (SAMPLE_DIV=4, DEBOUNCE_N=3, REPEAT_DELAY=10, REPEAT_RATE=4)
REQ-031 FIRE high for 40 CLK -> KEY_LVL[4]=1 after 3 differing ticks, one KEY_PRESS[4] pulse, FIRE_TOG 0->1; a second press sets FIRE_TOG to 0.
REQ-032 START pulses high for 8 CLK then low, repeated -> KEY_LVL[2] stays 0 with no pulses.
REQ-033 L held 200 CLK -> MOVE_L at press, next 40 CLK later, then every 16 CLK; release yields KEY_REL[0] and no further MOVE_L.
REQ-034 L held, then R pressed -> MOVE_R never pulses and MOVE_L stops while both are high; after R release, L restarts only on a fresh press.
REQ-035 RST_N driven low mid-RPT for 3 CLK with L still held -> all outputs 0 immediately; one KEY_PRESS[0] plus MOVE_L after 3 ticks.
REQ-036 STOP and R pressed in the same CLK -> KEY_PRESS[3] and KEY_PRESS[1] pulse in the same cycle.
